// File: rtl/key_pkg.sv
// Shared types and defaults for the key click controller.
// Behaviour selection macro: KEY_CLICK_DOUBLE_EN.
package key_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } click_state_t;

  localparam int KEY_WINDOW_CYCLES_DEF = 12_500_000;
  localparam int KEY_NUM_MODES_DEF     = 7;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/key_click_ctrl_mode_stepper.sv
// Wrapping up/down mode counter with registered one-hot decode and change pulse.
// inc and dec are never asserted together by the controller.
module mode_stepper
  import key_pkg::*;
#(
  parameter int NUM_MODES = KEY_NUM_MODES_DEF,
  parameter int MODE_W    = clog2_min1(KEY_NUM_MODES_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] mode_sel,
  output logic                 mode_changed
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  logic [MODE_W-1:0]    mode_reg, mode_next;
  logic [NUM_MODES-1:0] sel_reg, sel_next;
  logic                 changed_reg;

  always_comb begin
    mode_next = mode_reg;
    if (inc) begin
      mode_next = (mode_reg == MODE_LAST) ? '0 : mode_reg + 1'b1;
    end else if (dec) begin
      mode_next = (mode_reg == '0) ? MODE_LAST : mode_reg - 1'b1;
    end
  end

  // Decode from mode_next so the one-hot lands on the same edge as mode.
  generate
    for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_sel
      assign sel_next[gi] = (mode_next == MODE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg    <= '0;
      sel_reg     <= NUM_MODES'(1);
      changed_reg <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      sel_reg     <= sel_next;
      changed_reg <= inc | dec;
    end
  end

  assign mode         = mode_reg;
  assign mode_sel     = sel_reg;
  assign mode_changed = changed_reg;

endmodule

// File: rtl/key_click_ctrl.sv
// Classifies debounced key pulses into single/double clicks and steps a mode index.
// Double-click detection is built only when KEY_CLICK_DOUBLE_EN is defined.
module key_click_ctrl
  import key_pkg::*;
#(
  parameter int WINDOW_CYCLES = KEY_WINDOW_CYCLES_DEF,
  parameter int NUM_MODES     = KEY_NUM_MODES_DEF,
  localparam int MODE_W       = clog2_min1(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_pulse,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] mode_sel,
  output logic                 mode_changed,
  output logic                 dbl_click,
  output logic                 busy
);

  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("key_click_ctrl: WINDOW_CYCLES must be >= 2");
  end
  if (NUM_MODES < 2) begin : g_bad_modes
    $error("key_click_ctrl: NUM_MODES must be >= 2");
  end

  logic inc, dec;

`ifdef KEY_CLICK_DOUBLE_EN
  localparam int CNT_W = clog2_min1(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

  click_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg;
  logic             dbl_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      dbl_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == WAIT);
      dbl_reg   <= dec;
    end
  end

  // A pulse in WAIT wins over window expiry, and never reopens a window.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    inc        = 1'b0;
    dec        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_pulse) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        if (key_pulse) begin
          dec        = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          inc        = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign dbl_click = dbl_reg;
`else
  // Without double-click support every pulse is an immediate single click.
  assign inc       = key_pulse;
  assign dec       = 1'b0;
  assign busy      = 1'b0;
  assign dbl_click = 1'b0;
`endif

  mode_stepper #(
    .NUM_MODES(NUM_MODES),
    .MODE_W   (MODE_W)
  ) u_stepper (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .dec         (dec),
    .mode        (mode),
    .mode_sel    (mode_sel),
    .mode_changed(mode_changed)
  );

endmodule

// File: doc/key_click_ctrl.md
# key_click_ctrl

Consumes the single-cycle key pulses produced by the key debouncer and classifies them into single and double clicks within a configurable time window. Single clicks advance a wrapping mode index; double clicks step it back. The mode index and its one-hot decode drive tangram piece selection downstream. All outputs are registered.

## Interface

**Parameters**
- `WINDOW_CYCLES`, default 12_500_000: double-click window in clk cycles (250 ms at 50 MHz). Must be ≥ 2.
- `NUM_MODES`, default 7: number of modes. Must be ≥ 2.

**Ports**
- `clk`  in  1  system clock; sole clock of the block.
- `reset`  in  1  reset, synchronous and active-high.
- `key_pulse`  in  1  one-cycle pulse per debounced press, synchronous to `clk`.
- `mode`  out  MODE_W  current mode, 0..NUM_MODES-1. MODE_W = max(1, $clog2(NUM_MODES)).
- `mode_sel`  out  NUM_MODES  one-hot decode of `mode`; bit `mode` is set.
- `mode_changed`  out  1  one-cycle pulse, coincident with every `mode` update.
- `dbl_click`  out  1  one-cycle pulse when a double click is resolved.
- `busy`  out  1  high while a click window is open.

## Operation

- FSM states: IDLE, WAIT. Window counter `cnt` has width CNT_W = $clog2(WINDOW_CYCLES).
- IDLE:
  - `key_pulse`=1 → go to WAIT, `cnt`←0.
  - Otherwise stay in IDLE.
- WAIT (evaluated in priority order):
  1. `key_pulse`=1 → double click.
  2. Else if `cnt`==WINDOW_CYCLES-1 → single click.
  3. Else `cnt`←`cnt`+1.
  - Both click outcomes return the FSM to IDLE.
- Single click: `mode`←`mode`+1, wrapping NUM_MODES-1→0. Pulse `mode_changed`.
- Double click: `mode`←`mode`-1, wrapping 0→NUM_MODES-1. Pulse `dbl_click` and `mode_changed`.
- A pulse that resolves a double click never opens a new window. A third rapid press opens a fresh window.
- A pulse arriving in the same cycle the window expires counts as a double click (pulse has priority).
- `busy` = (state==WAIT), registered.
- `mode_sel` is updated on the same edge as `mode`.
- Reset values: state IDLE, `cnt`=0, `mode`=0, `mode_sel`=1, `mode_changed`=0, `dbl_click`=0, `busy`=0.
- Reset asserted mid-window discards the pending click: no `mode_changed` is issued and `mode` returns to 0.
- Inputs wider than one cycle are not expected. A `key_pulse` held high for k cycles is treated as k pulses.

## Timing

- Pulse sampled at edge E0 (IDLE) → `busy`=1 after E0.
- Second pulse sampled at edge Ek, 1 ≤ k ≤ WINDOW_CYCLES → double resolved at Ek:
  - `dbl_click`, `mode_changed` and the new `mode` are visible after Ek.
  - `busy`=0 after Ek.
- No second pulse → single resolved at edge E0+WINDOW_CYCLES:
  - `mode_changed` and the new `mode` are visible after that edge.
  - `busy` is high for exactly WINDOW_CYCLES cycles.
- A pulse at E0+WINDOW_CYCLES+1 or later is sampled in IDLE and starts a new window.
- `mode_changed` and `dbl_click` are never high for more than one consecutive cycle.

## Configuration

- Macro: `KEY_CLICK_DOUBLE_EN`.
- Defined: full behaviour as described above.
- Undefined:
  - No WAIT state and no window counter.
  - Every `key_pulse` sampled at edge E is a single click, resolved at E. `mode` and `mode_changed` are visible after E.
  - `busy` and `dbl_click` are tied to 0.
  - `mode` never decrements.

## Structure

- Shared package `key_pkg` holds:
  - FSM state typedef `click_state_t` (IDLE, WAIT).
  - Default constants `KEY_WINDOW_CYCLES_DEF` and `KEY_NUM_MODES_DEF`.
- Sub-module `mode_stepper`:
  - Up/down wrapping counter modulo NUM_MODES with registered one-hot decode.
  - Inputs: `inc`, `dec`. Outputs: `mode`, `mode_sel`, `mode_changed`.
  - `inc` and `dec` are mutually exclusive by construction.

## Test plan

Bench parameters: WINDOW_CYCLES=8, NUM_MODES=3, macro defined unless stated.

- Release reset → `mode`=0, `mode_sel`=3'b001, `busy`=0, `mode_changed`=0, `dbl_click`=0.
- One pulse at E0, no further pulses → `busy` high for exactly 8 cycles. `mode_changed` pulses after E0+8, `mode`=1, `mode_sel`=3'b010.
- From `mode`=0, pulses at E0 and E0+3 → after E0+3: `dbl_click`=1, `mode_changed`=1, `mode`=2, `busy`=0. No further `mode_changed` follows.
- Boundary:
  - Second pulse at E0+8 → double, `mode` decrements.
  - Second pulse at E0+9 → single resolves at E0+8 (`mode`+1), then a new window opens at E0+9.
- Three isolated single clicks → `mode` sequence 1, 2, 0. `mode_sel` tracks one-hot each time.
- Mid-window reset and macro off:
  - Reset asserted at E0+4 after a pulse → no `mode_changed`, `mode`=0, `busy`=0.
  - With the macro undefined, a pulse at E → `mode`+1 after E; `busy` and `dbl_click` stay 0 throughout.
